fft_frame_ctrl: RTL

Frame-level sequencer for the PE_full FFT pipeline. It:
- accepts a start command;
- latches per-stage scaling and select configuration;
- gates upstream sample valids into the PE chain against the PE ready handshake;
- counts N input and N output samples, then signals frame completion.

A watchdog flags a frame whose outputs stall. It sits between the stream source and the first PE stage, with a tap on the last stage's output valid.

---
 rtl/fft_frame_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fft_frame_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fft_frame_ctrl : frame sequencer for the PE FFT pipeline (rev 1.0)        |
// +--------------------------------------------------------------------------+
module fft_frame_ctrl #(
   parameter int N_LOG2    = 6,
   parameter int NUM_STAGE = 6,
   parameter int TIMEOUT   = 255
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [2*NUM_STAGE-1:0] scale_cfg,
   input  logic [NUM_STAGE-1:0]   sel_cfg,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   pe_ready,
   output logic                   pe_in_valid,
   input  logic                   out_valid,
   output logic [NUM_STAGE-1:0]   pe_select,
   output logic [2*NUM_STAGE-1:0] pe_scaling,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [N_LOG2:0]        in_cnt,
   output logic [N_LOG2:0]        out_cnt
);

   localparam int              CW       = N_LOG2 + 1;
   localparam int              WDW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]   N_CNT    = {1'b1, {N_LOG2{1'b0}}};
   localparam logic [WDW-1:0]  WD_LIMIT = WDW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t         state;
   state_t         next_state;
   logic [WDW-1:0] wdog;
   logic           xfer;
   logic           out_hit;
   logic           out_full_next;
   logic           wd_expire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state    = state;
      in_ready      = 1'b0;
      pe_in_valid   = 1'b0;
      xfer          = 1'b0;
      wd_expire     = 1'b0;
      // out_cnt saturates at N; the frame is output-complete when it gets there
      out_hit       = out_valid && ((state == LOAD) || (state == DRAIN)) && (out_cnt != N_CNT);
      out_full_next = (out_cnt == N_CNT) || (out_hit && (out_cnt == N_CNT - 1'b1));
      case (state)
         IDLE: begin
            if (start) next_state = LOAD;
         end
         LOAD: begin
            in_ready    = pe_ready;
            pe_in_valid = in_valid & pe_ready;
            xfer        = in_valid & pe_ready;
            if (xfer && (in_cnt == N_CNT - 1'b1))
               next_state = out_full_next ? DONE : DRAIN;
         end
         DRAIN: begin
            wd_expire = !out_valid && (wdog == WD_LIMIT - 1'b1);
            if (out_full_next)  next_state = DONE;
            else if (wd_expire) next_state = IDLE;
         end
         DONE: begin
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pe_select  <= '0;
         pe_scaling <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         in_cnt     <= '0;
         out_cnt    <= '0;
         wdog       <= '0;
      end else begin
         busy <= (next_state == LOAD) || (next_state == DRAIN);
         done <= (next_state == DONE);
         err  <= (state == DRAIN) && (next_state == IDLE);

         if ((state == IDLE) && start) begin
            pe_scaling <= scale_cfg;
            pe_select  <= sel_cfg;
            in_cnt     <= '0;
            out_cnt    <= '0;
         end else begin
            // config is released whenever a frame ends, normally or by timeout
            if ((state != IDLE) && (next_state == IDLE)) begin
               pe_scaling <= '0;
               pe_select  <= '0;
            end
            if (xfer)    in_cnt  <= in_cnt + 1'b1;
            if (out_hit) out_cnt <= out_cnt + 1'b1;
         end

         if ((state == DRAIN) && (next_state == DRAIN))
            wdog <= out_valid ? '0 : wdog + 1'b1;
         else
            wdog <= '0;
      end
   end

endmodule
`default_nettype wire
